// File: rtl/video_switch_pkg.sv
// Shared types and constants for the glitch-managed video source switch.
package video_switch_pkg;

  typedef enum logic [1:0] {RUN, WAIT_VB, MUTE} vsw_state_e;

  localparam int   CNT_W = 4;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Zero frames would never re-lock downstream, so clamp into 1..15.
  function automatic logic [CNT_W-1:0] mute_load(input int frames);
    if (frames < 1)  return CNT_W'(1);
    if (frames > 15) return CNT_W'(15);
    return CNT_W'(frames);
  endfunction

endpackage

// File: rtl/video_source_switch_if.sv
// Switch request/status handshake between the core control and video_source_switch.
interface video_source_switch_if;
  logic req_valid;
  logic req_src;
  logic busy;
  logic done;
  logic req_err;
  logic active_src;

  modport master (output req_valid, req_src, input busy, done, req_err, active_src);
  modport slave  (input req_valid, req_src, output busy, done, req_err, active_src);
endinterface

// File: rtl/vsw_edge_det.sv
// Rising-edge detect of VBlank/VSync for one source, history advanced only on ce_pix.
module vsw_edge_det (
  input  logic clk_vid,
  input  logic reset,
  input  logic ce_pix_i,
  input  logic vblank_i,
  input  logic vsync_i,
  output logic vb_rise_o,
  output logic vs_rise_o
);
  logic vb_q, vs_q;

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      vb_q <= 1'b0;
      vs_q <= 1'b0;
    end else if (ce_pix_i) begin
      vb_q <= vblank_i;
      vs_q <= vsync_i;
    end
  end

  assign vb_rise_o = ce_pix_i & vblank_i & ~vb_q;
  assign vs_rise_o = ce_pix_i & vsync_i  & ~vs_q;
endmodule

// File: rtl/video_source_switch.sv
// 2:1 video source selector: switch at old VBlank, then blank for MUTE_FRAMES new frames.
// Optional VIDEO_SWITCH_TIMEOUT_EN forces the switch if the old source never blanks.
module video_source_switch
  import video_switch_pkg::*;
#(
  parameter int COLOR_DEPTH  = 8,
  parameter int MUTE_FRAMES  = 2,
  parameter int TIMEOUT_CLKS = 2000000
) (
  input  logic                   clk_vid,
  input  logic                   reset,
  video_source_switch_if.slave   ctl,
  input  logic                   a_ce_pix,
  input  logic [COLOR_DEPTH-1:0] a_R, a_G, a_B,
  input  logic                   a_HSync, a_VSync, a_HBlank, a_VBlank,
  input  logic                   b_ce_pix,
  input  logic [COLOR_DEPTH-1:0] b_R, b_G, b_B,
  input  logic                   b_HSync, b_VSync, b_HBlank, b_VBlank,
  output logic                   ce_pix,
  output logic [COLOR_DEPTH-1:0] VGA_R, VGA_G, VGA_B,
  output logic                   VGA_HS, VGA_VS, HBlank_out, VBlank_out
);
  localparam logic [CNT_W-1:0] MUTE_LOAD = mute_load(MUTE_FRAMES);

  vsw_state_e       state_q, state_d;
  logic             active_q, active_d, tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             a_vb_rise, a_vs_rise, b_vb_rise, b_vs_rise;
  logic             vb_rise, vs_rise, timeout;

  // Both sources are tracked all the time so the incoming one has valid history.
  vsw_edge_det u_edge_a (
    .clk_vid, .reset, .ce_pix_i(a_ce_pix), .vblank_i(a_VBlank), .vsync_i(a_VSync),
    .vb_rise_o(a_vb_rise), .vs_rise_o(a_vs_rise)
  );
  vsw_edge_det u_edge_b (
    .clk_vid, .reset, .ce_pix_i(b_ce_pix), .vblank_i(b_VBlank), .vsync_i(b_VSync),
    .vb_rise_o(b_vb_rise), .vs_rise_o(b_vs_rise)
  );

  assign vb_rise = (active_q == SRC_B) ? b_vb_rise : a_vb_rise;
  assign vs_rise = (active_q == SRC_B) ? b_vs_rise : a_vs_rise;

`ifdef VIDEO_SWITCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TO_W-1:0] to_q, to_d;

  always_comb begin
    to_d    = (state_q == WAIT_VB) ? to_q + TO_W'(1) : '0;
    timeout = (state_q == WAIT_VB) && (to_d == TO_W'(TIMEOUT_CLKS));
  end

  always_ff @(posedge clk_vid) begin
    if (reset) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      RUN: begin
        if (ctl.req_valid) begin
          if (ctl.req_src == active_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = ctl.req_src;
            busy_d  = 1'b1;
            state_d = WAIT_VB;
          end
        end
      end
      WAIT_VB: begin
        err_d = ctl.req_valid;
        if (vb_rise || timeout) begin
          active_d = tgt_q;
          cnt_d    = MUTE_LOAD;
          state_d  = MUTE;
        end
      end
      MUTE: begin
        err_d = ctl.req_valid;
        if (vs_rise) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      state_q  <= RUN;
      active_q <= SRC_A;
      tgt_q    <= SRC_A;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ctl.busy       = busy_q;
  assign ctl.done       = done_q;
  assign ctl.req_err    = err_q;
  assign ctl.active_src = active_q;

  // Routed video: sync and ce pass through untouched; colour/blank forced while muting.
  logic mute;
  assign mute = (state_q == MUTE);

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      ce_pix     <= 1'b0;
      VGA_R      <= '0;
      VGA_G      <= '0;
      VGA_B      <= '0;
      VGA_HS     <= 1'b0;
      VGA_VS     <= 1'b0;
      HBlank_out <= 1'b1;
      VBlank_out <= 1'b1;
    end else if (active_q == SRC_B) begin
      ce_pix     <= b_ce_pix;
      VGA_R      <= mute ? '0 : b_R;
      VGA_G      <= mute ? '0 : b_G;
      VGA_B      <= mute ? '0 : b_B;
      VGA_HS     <= b_HSync;
      VGA_VS     <= b_VSync;
      HBlank_out <= mute | b_HBlank;
      VBlank_out <= mute | b_VBlank;
    end else begin
      ce_pix     <= a_ce_pix;
      VGA_R      <= mute ? '0 : a_R;
      VGA_G      <= mute ? '0 : a_G;
      VGA_B      <= mute ? '0 : a_B;
      VGA_HS     <= a_HSync;
      VGA_VS     <= a_VSync;
      HBlank_out <= mute | a_HBlank;
      VBlank_out <= mute | a_VBlank;
    end
  end
endmodule

// File: tb/tb_video_source_switch.sv
// Randomized-video bench for video_source_switch against a frame-level reference model.
module tb_video_source_switch;
  localparam int CD = 8;
  localparam int MF = 2;
  localparam int TO = 100;
`ifdef VIDEO_SWITCH_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk_vid = 1'b0;
  logic reset;
  always #5 clk_vid = ~clk_vid;

  video_source_switch_if ctl ();

  // Per-source stimulus, index 0 = A, 1 = B.
  logic          sce[2], shs[2], svs[2], shb[2], svb[2];
  logic [CD-1:0] scol[2][3];
  int            pos[2];
  int            flen[2];
  bit            ce_off[2];
  int            fix_ar;

  logic          ce_pix, VGA_HS, VGA_VS, HBlank_out, VBlank_out;
  logic [CD-1:0] VGA_R, VGA_G, VGA_B;

  video_source_switch #(.COLOR_DEPTH(CD), .MUTE_FRAMES(MF), .TIMEOUT_CLKS(TO)) dut (
    .clk_vid(clk_vid), .reset(reset), .ctl(ctl),
    .a_ce_pix(sce[0]), .a_R(scol[0][0]), .a_G(scol[0][1]), .a_B(scol[0][2]),
    .a_HSync(shs[0]), .a_VSync(svs[0]), .a_HBlank(shb[0]), .a_VBlank(svb[0]),
    .b_ce_pix(sce[1]), .b_R(scol[1][0]), .b_G(scol[1][1]), .b_B(scol[1][2]),
    .b_HSync(shs[1]), .b_VSync(svs[1]), .b_HBlank(shb[1]), .b_VBlank(svb[1]),
    .ce_pix(ce_pix), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .HBlank_out(HBlank_out), .VBlank_out(VBlank_out)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Toy frame generators: each source walks a short frame on its own random ce.
  task automatic drive_video();
    for (int s = 0; s < 2; s++) begin
      sce[s] = !ce_off[s] && ($urandom_range(3) != 0);
      if (sce[s]) begin
        pos[s] = (pos[s] + 1) % flen[s];
        svb[s] = pos[s] >= flen[s] - 8;
        svs[s] = (pos[s] >= flen[s] - 6) && (pos[s] < flen[s] - 3);
        shs[s] = (pos[s] % 5) == 0;
        shb[s] = ((pos[s] % 5) < 2) || svb[s];
        for (int c = 0; c < 3; c++) scol[s][c] = CD'($urandom);
      end
    end
    if (fix_ar >= 0) scol[0][0] = CD'(fix_ar);
  endtask

  // Reference model: which source is live, which is pending, frames of blank left.
  int         live, pend, mute_left, wait_cyc;
  bit         pvb[2], pvs[2];
  logic [28:0] exp_vid;
  logic [3:0]  exp_ctl;

  task automatic model_edge();
    bit vbr[2], vsr[2];
    bit muted, done, err;
    logic [23:0] col;
    if (reset) begin
      live = 0; pend = -1; mute_left = 0; wait_cyc = 0;
      pvb = '{0, 0}; pvs = '{0, 0};
      exp_vid = {1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_ctl = 4'b0000;
      return;
    end
    for (int s = 0; s < 2; s++) begin
      vbr[s] = sce[s] && svb[s] && !pvb[s];
      vsr[s] = sce[s] && svs[s] && !pvs[s];
    end
    muted = mute_left > 0;
    col = muted ? 24'h0 : {scol[live][0], scol[live][1], scol[live][2]};
    exp_vid = {sce[live], col, shs[live], svs[live], muted | shb[live], muted | svb[live]};
    done = 0; err = 0;
    if (mute_left > 0) begin
      err = ctl.req_valid;
      if (vsr[live]) begin
        mute_left--;
        if (mute_left == 0) done = 1;
      end
    end else if (pend >= 0) begin
      err = ctl.req_valid;
      wait_cyc++;
      if (vbr[live] || (TIMEOUT_ON && wait_cyc == TO)) begin
        live = pend; pend = -1; mute_left = MF;
      end
    end else if (ctl.req_valid) begin
      if (int'(ctl.req_src) == live) done = 1;
      else begin pend = int'(ctl.req_src); wait_cyc = 0; end
    end
    for (int s = 0; s < 2; s++) if (sce[s]) begin pvb[s] = svb[s]; pvs[s] = svs[s]; end
    exp_ctl = {(pend >= 0) || (mute_left > 0), done, err, live[0]};
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_vid);
    #1;
    chk("video", {3'b0, ce_pix, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, HBlank_out, VBlank_out},
        {3'b0, exp_vid});
    chk("ctl", {28'h0, ctl.busy, ctl.done, ctl.req_err, ctl.active_src}, {28'h0, exp_ctl});
    ctl.req_valid = 1'b0;
    drive_video();
  endtask

  task automatic wait_done(input string tag, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (ctl.done) begin seen = 1; break; end
    end
    chk(tag, {31'h0, seen}, 32'h1);
  endtask

  initial begin
    bit seen, injected;
    flen = '{40, 30};
    pos = '{0, 0};
    ce_off = '{0, 0};
    fix_ar = -1;
    for (int s = 0; s < 2; s++) begin
      sce[s] = 0; shs[s] = 0; svs[s] = 0; shb[s] = 0; svb[s] = 0;
      for (int c = 0; c < 3; c++) scol[s][c] = '0;
    end
    reset = 1'b1;
    ctl.req_valid = 1'b0;
    ctl.req_src = 1'b0;
    drive_video();
    repeat (3) step();
    chk("rst_blank", {30'h0, HBlank_out, VBlank_out}, 32'h3);

    // Source A passes straight through, fixed red level.
    reset = 1'b0;
    fix_ar = 8'h55;
    drive_video();
    repeat (20) step();
    chk("a_red_55", {24'h0, VGA_R}, 32'h55);
    fix_ar = -1;

    // Request for the already-live source: immediate done, no mute.
    ctl.req_valid = 1'b1; ctl.req_src = 1'b0;
    step();
    chk("same_done", {30'h0, ctl.done, ctl.busy}, 32'h2);

    // Switch A->B mid-frame, with a rejected second request while muting.
    repeat (13) step();
    ctl.req_valid = 1'b1; ctl.req_src = 1'b1;
    step();
    chk("sw_busy", {31'h0, ctl.busy}, 32'h1);
    seen = 0; injected = 0;
    for (int i = 0; i < 600; i++) begin
      if (!injected && mute_left > 0) begin
        ctl.req_valid = 1'b1; ctl.req_src = 1'b0; injected = 1;
        step();
        chk("mute_err", {31'h0, ctl.req_err}, 32'h1);
      end else step();
      if (ctl.done) begin seen = 1; break; end
    end
    chk("sw_b_done", {31'h0, seen}, 32'h1);
    chk("sw_b_live", {31'h0, ctl.active_src}, 32'h1);
    repeat (10) step();

    // Request in the same cycle as a B VBlank rise: must wait for the next frame.
    for (int i = 0; i < 200; i++) begin
      if (sce[1] && svb[1] && !pvb[1]) break;
      step();
    end
    ctl.req_valid = 1'b1; ctl.req_src = 1'b0;
    step();
    step();
    chk("coinc_still_b", {31'h0, ctl.active_src}, 32'h1);
    wait_done("sw_a_done", 600);
    chk("sw_a_live", {31'h0, ctl.active_src}, 32'h0);

    // Reset while muting: back to A, no done.
    ctl.req_valid = 1'b1; ctl.req_src = 1'b1;
    step();
    for (int i = 0; i < 300 && mute_left == 0; i++) step();
    chk("reached_mute", {31'h0, mute_left > 0}, 32'h1);
    step();
    reset = 1'b1;
    step();
    chk("rst_mid", {29'h0, ctl.busy, ctl.done, ctl.active_src}, 32'h0);
    reset = 1'b0;
    repeat (5) step();

    // Stopped old source: only the timeout build may leave WAIT_VB.
    ce_off[0] = 1;
    drive_video();
    ctl.req_valid = 1'b1; ctl.req_src = 1'b1;
    step();
    repeat (150) step();
    chk("stalled_src", {31'h0, ctl.active_src}, {31'h0, TIMEOUT_ON});
    chk("stalled_busy", {31'h0, ctl.busy}, 32'h1);
    ce_off[0] = 0;
    wait_done("stall_done", 600);
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
